// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
// Shared constants for the VGA framebuffer read path.
//   H_OFFSET : pix_x value of the first visible column
//   FB_W/FB_H: framebuffer geometry (half of the 640x480 visible area)
//   ACTIVE_W/ACTIVE_H: visible area seen by the pixel iterator
//   RGB_W    : width of a packed {R4,G4,B4} pixel
// row_x320() is the shift-add row base used when FB_W is 320.
// ---------------------------------------------------------------------------
package vga_pkg;

    localparam int H_OFFSET = 160;
    localparam int FB_W     = 320;
    localparam int FB_H     = 240;
    localparam int ACTIVE_W = 640;
    localparam int ACTIVE_H = 480;
    localparam int RGB_W    = 12;

    // r*320 = r*256 + r*64, kept as two shifts so no multiplier is inferred.
    function automatic int unsigned row_x320(input logic [7:0] r);
        int unsigned rr;
        rr = {24'd0, r};
        return (rr << 8) + (rr << 6);
    endfunction

endpackage

// File: rtl/vga_fb_reader_if.sv
// ---------------------------------------------------------------------------
// vga_fb_reader_if
// Bundles the framebuffer read port and the buffer-swap handshake.
//   mem_addr/mem_rd : read request from the reader
//   mem_data        : read data, returned a fixed number of pixel strobes later
//   swap_req        : level from the drawing engine, held until swap_ack
//   swap_ack        : one-clk pulse from the reader when the swap is taken
// Handshake: swap_req is a level; the reader samples it only on the pixel
// strobe that carries screen_end and answers with a single-clk swap_ack.
// A request still high at a later screen_end is taken again.
// Modports: master = reader side, slave = memory/drawer side.
// ---------------------------------------------------------------------------
interface vga_fb_reader_if
    import vga_pkg::*;
#(
    parameter int ADDR_W = 18
) ();

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic [RGB_W-1:0]  mem_data;
    logic              swap_req;
    logic              swap_ack;

    modport master (
        output mem_addr, mem_rd, swap_ack,
        input  mem_data, swap_req
    );

    modport slave (
        input  mem_addr, mem_rd, swap_ack,
        output mem_data, swap_req
    );

endinterface

// File: rtl/vga_delay_line.sv
// ---------------------------------------------------------------------------
// vga_delay_line
// DEPTH-stage shift register that advances only when en is high.
//   clk, rst (async, active-low), en : clocking / reset / advance enable
//   d -> q                            : WIDTH-bit data, DEPTH enabled cycles late
// RST_VAL lets sync bits reset to their idle-high level.
// ---------------------------------------------------------------------------
module vga_delay_line #(
    parameter int               WIDTH   = 1,
    parameter int               DEPTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= RST_VAL;
            end
        end else if (en) begin
            stage[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[DEPTH-1];

endmodule

// File: rtl/vga_fb_reader.sv
// ---------------------------------------------------------------------------
// vga_fb_reader
// Pixel-fetch stage behind the VGA pixel iterator. Turns iterator
// coordinates into reads of a double-buffered 320x240 framebuffer (2x
// scaling), lines returned colour up with equally delayed syncs, and swaps
// front/back buffers with the drawing engine at end of frame.
// Ports:
//   clk, rst (async, active-low), pix_clk (one-clk pixel strobe)
//   pix_x, pix_y, draw_active, h_sync_i, v_sync_i, screen_end, draw_end
//                 : iterator outputs
//   bus           : framebuffer read port + swap handshake (master side)
//   front_sel     : buffer currently displayed
//   vblank_start  : one-clk pulse when draw_end rises
//   rgb, h_sync, v_sync : aligned pixel output, MEM_LAT+2 strobes after input
// Pipeline: A (address register) -> MEM_LAT-deep delay line -> C (output).
// ---------------------------------------------------------------------------
module vga_fb_reader #(
    parameter int H_OFFSET = vga_pkg::H_OFFSET,
    parameter int FB_W     = vga_pkg::FB_W,
    parameter int FB_H     = vga_pkg::FB_H,
    parameter int MEM_LAT  = 2,   // read latency in pixel strobes, 1..4
    parameter int ADDR_W   = 18
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      pix_clk,
    input  logic [9:0]                pix_x,
    input  logic [8:0]                pix_y,
    input  logic                      draw_active,
    input  logic                      h_sync_i,
    input  logic                      v_sync_i,
    input  logic                      screen_end,
    input  logic                      draw_end,
    vga_fb_reader_if.master           bus,
    output logic                      front_sel,
    output logic                      vblank_start,
    output logic [vga_pkg::RGB_W-1:0] rgb,
    output logic                      h_sync,
    output logic                      v_sync
);

    import vga_pkg::*;

    localparam logic [ADDR_W-1:0] BUF_WORDS = ADDR_W'(FB_W * FB_H);

    // ---------------- stage A: address generation ----------------
    // pix_x below H_OFFSET wraps col to >= 640, so it falls out as blank.
    logic [9:0]        col;
    logic [7:0]        row_half;
    logic [8:0]        col_half;
    logic              fetch;
    logic [ADDR_W-1:0] row_base;
    logic [ADDR_W-1:0] addr_next;

    assign col      = pix_x - 10'(H_OFFSET);
    assign row_half = 8'(pix_y >> 1);
    assign col_half = 9'(col >> 1);
    assign fetch    = draw_active && (col < 10'(ACTIVE_W)) && (pix_y < 9'(ACTIVE_H));

    generate
        if (FB_W == 320) begin : g_row_shift_add
            assign row_base = ADDR_W'(row_x320(row_half));
        end else begin : g_row_generic
            assign row_base = ADDR_W'(row_half) * ADDR_W'(FB_W);
        end
    endgenerate

    assign addr_next = (front_sel ? BUF_WORDS : '0) + row_base + ADDR_W'(col_half);

    logic a_fetch;
    logic a_hs;
    logic a_vs;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.mem_addr <= '0;
            bus.mem_rd   <= 1'b0;
            a_fetch      <= 1'b0;
            a_hs         <= 1'b1;
            a_vs         <= 1'b1;
        end else begin
            // read strobe lives for exactly the clk after an enabled edge
            bus.mem_rd <= pix_clk && fetch;
            if (pix_clk) begin
                bus.mem_addr <= addr_next;
                a_fetch      <= fetch;
                a_hs         <= h_sync_i;
                a_vs         <= v_sync_i;
            end
        end
    end

    // ---------------- stage B: align control with memory latency ----------------
    logic d_fetch;
    logic d_hs;
    logic d_vs;

    vga_delay_line #(
        .WIDTH   (3),
        .DEPTH   (MEM_LAT),
        .RST_VAL (3'b011)
    ) u_align (
        .clk (clk),
        .rst (rst),
        .en  (pix_clk),
        .d   ({a_fetch, a_hs, a_vs}),
        .q   ({d_fetch, d_hs, d_vs})
    );

    // ---------------- stage C: output register ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rgb    <= '0;
            h_sync <= 1'b1;
            v_sync <= 1'b1;
        end else if (pix_clk) begin
            rgb    <= d_fetch ? bus.mem_data : '0;
            h_sync <= d_hs;
            v_sync <= d_vs;
        end
    end

    // ---------------- buffer swap and vblank detect ----------------
    // Both actions are independent, so a coincident screen_end/draw_end
    // strobe produces both.
    logic draw_end_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            front_sel    <= 1'b0;
            bus.swap_ack <= 1'b0;
            vblank_start <= 1'b0;
            draw_end_q   <= 1'b0;
        end else begin
            bus.swap_ack <= 1'b0;
            vblank_start <= 1'b0;
            if (pix_clk) begin
                draw_end_q <= draw_end;
                if (draw_end && !draw_end_q) begin
                    vblank_start <= 1'b1;
                end
                if (screen_end && bus.swap_req) begin
                    front_sel    <= ~front_sel;
                    bus.swap_ack <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_vga_fb_reader.sv
// ---------------------------------------------------------------------------
// tb_vga_fb_reader
// Directed bench for vga_fb_reader with MEM_LAT=2. The memory model returns
// the low 12 bits of the address, or 12'hFFF while mem_force is set.
// ---------------------------------------------------------------------------
module tb_vga_fb_reader;

    logic        clk;
    logic        rst;
    logic        pix_clk;
    logic [9:0]  pix_x;
    logic [8:0]  pix_y;
    logic        draw_active;
    logic        h_sync_i;
    logic        v_sync_i;
    logic        screen_end;
    logic        draw_end;
    logic        front_sel;
    logic        vblank_start;
    logic [11:0] rgb;
    logic        h_sync;
    logic        v_sync;

    int tests_run;
    int tests_failed;

    vga_fb_reader_if #(.ADDR_W(18)) bus ();

    vga_fb_reader #(.MEM_LAT(2), .ADDR_W(18)) dut (
        .clk          (clk),
        .rst          (rst),
        .pix_clk      (pix_clk),
        .pix_x        (pix_x),
        .pix_y        (pix_y),
        .draw_active  (draw_active),
        .h_sync_i     (h_sync_i),
        .v_sync_i     (v_sync_i),
        .screen_end   (screen_end),
        .draw_end     (draw_end),
        .bus          (bus.master),
        .front_sel    (front_sel),
        .vblank_start (vblank_start),
        .rgb          (rgb),
        .h_sync       (h_sync),
        .v_sync       (v_sync)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- memory model: two strobe-advanced stages ----------------
    logic [11:0] mem_p1;
    logic [11:0] mem_p2;
    logic        mem_force;

    always @(posedge clk) begin
        if (pix_clk) begin
            mem_p1 <= bus.mem_addr[11:0];
            mem_p2 <= mem_p1;
        end
    end

    assign bus.mem_data = mem_force ? 12'hFFF : mem_p2;

    // ---------------- driver tasks ----------------
    task automatic set_pix(input int x, input int y, input logic act,
                           input logic hs, input logic vs);
        pix_x       = 10'(x);
        pix_y       = 9'(y);
        draw_active = act;
        h_sync_i    = hs;
        v_sync_i    = vs;
    endtask

    // one pix_clk strobe; returns 1 time unit after the enabled edge
    task automatic strobe();
        pix_clk = 1'b1;
        @(posedge clk);
        #1;
        pix_clk = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b0;
        idle(3);
        rst = 1'b1;
        idle(1);
        for (int k = 0; k < 6; k++) begin
            set_pix(160 + 2 * k, 2, 1'b1, 1'b0, 1'b0);
            strobe();
        end
        tests_run++;
        if (rgb !== 12'd322) begin
            tests_failed++;
            $display("FAIL reset_prestream_rgb: got %0d expected 322", rgb);
        end
        #2;
        rst = 1'b0;
        #1;
        tests_run++;
        if (rgb !== 12'd0) begin
            tests_failed++;
            $display("FAIL reset_rgb: got %0d expected 0", rgb);
        end
        tests_run++;
        if (h_sync !== 1'b1 || v_sync !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_sync: got h=%0b v=%0b expected h=1 v=1", h_sync, v_sync);
        end
        tests_run++;
        if (bus.mem_rd !== 1'b0 || bus.mem_addr !== 18'd0) begin
            tests_failed++;
            $display("FAIL reset_mem: got rd=%0b addr=%0d expected rd=0 addr=0",
                     bus.mem_rd, bus.mem_addr);
        end
        @(negedge clk);
        rst = 1'b1;
        idle(1);
    endtask

    // pixel at strobe j reaches rgb/h_sync after strobe j+3 (4th strobe)
    task automatic test_latency();
        logic [11:0] exp_rgb;
        logic        exp_hs;
        for (int j = 0; j < 10; j++) begin
            set_pix(160 + 2 * j, 2, 1'b1, (j < 3), 1'b1);
            strobe();
            exp_rgb = (j >= 3) ? 12'(320 + j - 3) : 12'd0;
            exp_hs  = (j >= 3) ? ((j - 3) < 3) : 1'b1;
            tests_run++;
            if (rgb !== exp_rgb) begin
                tests_failed++;
                $display("FAIL latency_rgb[%0d]: got %0d expected %0d", j, rgb, exp_rgb);
            end
            tests_run++;
            if (h_sync !== exp_hs) begin
                tests_failed++;
                $display("FAIL latency_hsync[%0d]: got %0b expected %0b", j, h_sync, exp_hs);
            end
        end
    endtask

    task automatic test_address();
        int          xs[3]  = '{161, 162, 799};
        int          ys[3]  = '{1, 2, 479};
        logic [17:0] exp[3] = '{18'd0, 18'd321, 18'd76799};
        for (int i = 0; i < 3; i++) begin
            set_pix(xs[i], ys[i], 1'b1, 1'b1, 1'b1);
            strobe();
            tests_run++;
            if (bus.mem_addr !== exp[i] || bus.mem_rd !== 1'b1) begin
                tests_failed++;
                $display("FAIL addr_scale[%0d]: got addr=%0d rd=%0b expected addr=%0d rd=1",
                         i, bus.mem_addr, bus.mem_rd, exp[i]);
            end
        end
        idle(1);
        tests_run++;
        if (bus.mem_rd !== 1'b0) begin
            tests_failed++;
            $display("FAIL rd_one_clk: got %0b expected 0", bus.mem_rd);
        end
    endtask

    task automatic test_blanking();
        mem_force = 1'b1;
        for (int j = 0; j < 8; j++) begin
            set_pix(200, 10, 1'b0, 1'b1, 1'b1);
            strobe();
            tests_run++;
            if (bus.mem_rd !== 1'b0) begin
                tests_failed++;
                $display("FAIL blank_rd[%0d]: got %0b expected 0", j, bus.mem_rd);
            end
            if (j >= 3) begin
                tests_run++;
                if (rgb !== 12'h000) begin
                    tests_failed++;
                    $display("FAIL blank_rgb[%0d]: got %h expected 000", j, rgb);
                end
            end
        end
        set_pix(800, 10, 1'b1, 1'b1, 1'b1);
        strobe();
        tests_run++;
        if (bus.mem_rd !== 1'b0) begin
            tests_failed++;
            $display("FAIL col640_rd: got %0b expected 0", bus.mem_rd);
        end
        strobe(); strobe(); strobe();
        tests_run++;
        if (rgb !== 12'h000) begin
            tests_failed++;
            $display("FAIL col640_rgb: got %h expected 000", rgb);
        end
        set_pix(200, 10, 1'b1, 1'b1, 1'b1);
        strobe();
        set_pix(200, 10, 1'b0, 1'b1, 1'b1);
        strobe(); strobe(); strobe();
        tests_run++;
        if (rgb !== 12'hFFF) begin
            tests_failed++;
            $display("FAIL active_fff_rgb: got %h expected fff", rgb);
        end
        mem_force = 1'b0;
    endtask

    task automatic test_stall();
        for (int j = 0; j < 4; j++) begin
            set_pix(170, 4, 1'b1, 1'b1, 1'b1);
            strobe();
        end
        set_pix(300, 20, 1'b1, 1'b0, 1'b0);
        for (int j = 0; j < 10; j++) begin
            idle(1);
            tests_run++;
            if (bus.mem_rd !== 1'b0 || bus.mem_addr !== 18'd645 || rgb !== 12'd645
                || h_sync !== 1'b1 || v_sync !== 1'b1) begin
                tests_failed++;
                $display("FAIL stall[%0d]: got rd=%0b addr=%0d rgb=%0d hs=%0b vs=%0b expected rd=0 addr=645 rgb=645 hs=1 vs=1",
                         j, bus.mem_rd, bus.mem_addr, rgb, h_sync, v_sync);
            end
        end
    endtask

    task automatic test_swap();
        bus.swap_req = 1'b1;
        set_pix(200, 100, 1'b1, 1'b1, 1'b1);
        strobe();
        tests_run++;
        if (front_sel !== 1'b0 || bus.swap_ack !== 1'b0) begin
            tests_failed++;
            $display("FAIL swap_wait: got sel=%0b ack=%0b expected sel=0 ack=0", front_sel, bus.swap_ack);
        end
        set_pix(0, 479, 1'b0, 1'b1, 1'b1);
        screen_end = 1'b1;
        strobe();
        tests_run++;
        if (front_sel !== 1'b1 || bus.swap_ack !== 1'b1) begin
            tests_failed++;
            $display("FAIL swap_take: got sel=%0b ack=%0b expected sel=1 ack=1", front_sel, bus.swap_ack);
        end
        screen_end   = 1'b0;
        bus.swap_req = 1'b0;
        idle(1);
        tests_run++;
        if (bus.swap_ack !== 1'b0) begin
            tests_failed++;
            $display("FAIL swap_ack_pulse: got %0b expected 0", bus.swap_ack);
        end
        set_pix(160, 0, 1'b1, 1'b1, 1'b1);
        strobe();
        tests_run++;
        if (bus.mem_addr !== 18'd76800) begin
            tests_failed++;
            $display("FAIL swap_addr_first: got %0d expected 76800", bus.mem_addr);
        end
        set_pix(163, 3, 1'b1, 1'b1, 1'b1);
        strobe();
        tests_run++;
        if (bus.mem_addr !== 18'd77121) begin
            tests_failed++;
            $display("FAIL swap_addr_back: got %0d expected 77121", bus.mem_addr);
        end
        // request withdrawn before screen_end: no swap
        bus.swap_req = 1'b1;
        strobe();
        bus.swap_req = 1'b0;
        strobe();
        screen_end = 1'b1;
        strobe();
        screen_end = 1'b0;
        tests_run++;
        if (front_sel !== 1'b1 || bus.swap_ack !== 1'b0) begin
            tests_failed++;
            $display("FAIL swap_dropped: got sel=%0b ack=%0b expected sel=1 ack=0", front_sel, bus.swap_ack);
        end
        // request held across two screen_ends: two swaps
        bus.swap_req = 1'b1;
        screen_end   = 1'b1;
        strobe();
        screen_end = 1'b0;
        tests_run++;
        if (front_sel !== 1'b0 || bus.swap_ack !== 1'b1) begin
            tests_failed++;
            $display("FAIL swap_held_1: got sel=%0b ack=%0b expected sel=0 ack=1", front_sel, bus.swap_ack);
        end
        strobe(); strobe();
        tests_run++;
        if (front_sel !== 1'b0 || bus.swap_ack !== 1'b0) begin
            tests_failed++;
            $display("FAIL swap_held_mid: got sel=%0b ack=%0b expected sel=0 ack=0", front_sel, bus.swap_ack);
        end
        screen_end = 1'b1;
        strobe();
        screen_end   = 1'b0;
        bus.swap_req = 1'b0;
        tests_run++;
        if (front_sel !== 1'b1 || bus.swap_ack !== 1'b1) begin
            tests_failed++;
            $display("FAIL swap_held_2: got sel=%0b ack=%0b expected sel=1 ack=1", front_sel, bus.swap_ack);
        end
    endtask

    task automatic test_vblank();
        draw_end = 1'b0;
        strobe();
        draw_end = 1'b1;
        strobe();
        tests_run++;
        if (vblank_start !== 1'b1) begin
            tests_failed++;
            $display("FAIL vblank_rise: got %0b expected 1", vblank_start);
        end
        idle(1);
        tests_run++;
        if (vblank_start !== 1'b0) begin
            tests_failed++;
            $display("FAIL vblank_pulse: got %0b expected 0", vblank_start);
        end
        strobe();
        tests_run++;
        if (vblank_start !== 1'b0) begin
            tests_failed++;
            $display("FAIL vblank_level: got %0b expected 0", vblank_start);
        end
        // coincident screen_end and draw_end rise
        draw_end = 1'b0;
        strobe();
        draw_end     = 1'b1;
        screen_end   = 1'b1;
        bus.swap_req = 1'b1;
        strobe();
        tests_run++;
        if (vblank_start !== 1'b1 || bus.swap_ack !== 1'b1 || front_sel !== 1'b0) begin
            tests_failed++;
            $display("FAIL coincident: got vb=%0b ack=%0b sel=%0b expected vb=1 ack=1 sel=0",
                     vblank_start, bus.swap_ack, front_sel);
        end
        draw_end     = 1'b0;
        screen_end   = 1'b0;
        bus.swap_req = 1'b0;
        idle(1);
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b0;
        pix_clk      = 1'b0;
        mem_force    = 1'b0;
        screen_end   = 1'b0;
        draw_end     = 1'b0;
        bus.swap_req = 1'b0;
        set_pix(0, 0, 1'b0, 1'b1, 1'b1);
        #1;
        test_reset();
        test_latency();
        test_address();
        test_blanking();
        test_stall();
        test_swap();
        test_vblank();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
